// File: rtl/rr_mux_pkg.sv
// Shared helpers for the round-robin multiplexer.
// Latency: none (functions only).
// Backpressure: not applicable.
package rr_mux_pkg;

    // Channel that sits 'offset' places above 'base', wrapping at n with a
    // compare so non-power-of-two channel counts never alias.
    function automatic int rr_rot_idx(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter: one-hot grant and index from a rotating priority pointer.
// Latency: grant is combinational from mask; pointer moves on the edge after adv.
// Backpressure: pointer holds whenever adv is low.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int channels_p = 4,
    parameter int sel_width_lp = $clog2(channels_p)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [channels_p-1:0]   mask,
    input  logic                    adv,
    output logic [channels_p-1:0]   grant,
    output logic [sel_width_lp-1:0] grant_idx
);

    logic [sel_width_lp-1:0] ptr;
    logic [sel_width_lp-1:0] cand;
    logic                    found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < channels_p; i++) begin
            cand = sel_width_lp'(rr_rot_idx(int'(ptr), i, channels_p));
            if (!found && mask[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv) begin
            if (grant_idx == sel_width_lp'(channels_p - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel round-robin mux into a one-beat output register; RR_MUX_LAST_EN adds packet locking.
// Latency: 1 cycle from input accept to valid_o/data_o.
// Backpressure: ready_o is zero while a held beat is stalled by ready_i low.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int width_p = 8,
    parameter int channels_p = 4,
    localparam int sel_width_lp = $clog2(channels_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [channels_p-1:0]         valid_i,
    input  logic [channels_p*width_p-1:0] data_i,
    output logic [channels_p-1:0]         ready_o,
`ifdef RR_MUX_LAST_EN
    input  logic [channels_p-1:0]         last_i,
    output logic                          last_o,
`endif
    output logic                          valid_o,
    output logic [width_p-1:0]            data_o,
    output logic [sel_width_lp-1:0]       sel_o,
    input  logic                          ready_i
);

    logic                    load_en;
    logic                    accept;
    logic [channels_p-1:0]   mask;
    logic [channels_p-1:0]   grant;
    logic [sel_width_lp-1:0] grant_idx;

    assign load_en = ~valid_o | ready_i;
    // Reset gating keeps producers from seeing an accept that the register would drop.
    assign ready_o = (load_en & ~reset_i) ? grant : '0;
    assign accept  = |ready_o;

`ifdef RR_MUX_LAST_EN
    logic                    lock;
    logic [sel_width_lp-1:0] lock_idx;

    always_comb begin
        mask = valid_i;
        if (lock) begin
            mask = valid_i & (channels_p'(1) << lock_idx);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock     <= 1'b0;
            lock_idx <= '0;
            last_o   <= 1'b0;
        end else if (accept) begin
            lock     <= ~last_i[grant_idx];
            lock_idx <= grant_idx;
            last_o   <= last_i[grant_idx];
        end
    end
`else
    assign mask = valid_i;
`endif

    rr_arbiter #(
        .channels_p   (channels_p),
        .sel_width_lp (sel_width_lp)
    ) u_arb (
        .clk       (clk_i),
        .reset     (reset_i),
        .mask      (mask),
        .adv       (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sel_o   <= '0;
        end else if (accept) begin
            valid_o <= 1'b1;
            data_o  <= data_i[int'(grant_idx)*width_p +: width_p];
            sel_o   <= grant_idx;
        end else if (load_en) begin
            valid_o <= 1'b0;
        end
    end

endmodule
